// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM state encoding
// and the opCode values.
package atm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LANG,
    PIN,
    MENU,
    BALANCE,
    DEPOSIT,
    WITHDRAW,
    ANOTHER,
    FINISH
  } state_t;

  localparam logic [1:0] OP_BAL  = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_WDR  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

endpackage

// File: rtl/atm_controller.sv
// Single-account ATM session FSM with registered outputs and balance.
// Define ATM_PIN_LOCKOUT_EN to lock the machine after MAX_TRIES wrong PINs.
module atm_controller
  import atm_pkg::*;
#(
  parameter logic [3:0]  PASSWORD     = 4'b1010,
  parameter logic [31:0] INIT_BALANCE = 32'd1000
`ifdef ATM_PIN_LOCKOUT_EN
  ,
  parameter int          MAX_TRIES    = 3
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cardIn,
  input  logic        Language,
  input  logic [3:0]  password,
  input  logic [1:0]  opCode,
  input  logic [6:0]  inputAmount,
  input  logic        moneyDeposited,
  input  logic        Another_Operation,
  input  logic        ejectCard,
  output logic        correctPassword,
  output logic        Balance_Shown,
  output logic        Deposited_Successfully,
  output logic        Withdrawed_Successfully,
  output logic        Input_Approved,
  output logic        ATM_Usage_Finished,
  output logic [31:0] Current_Balance
);

  state_t      state;
  logic        lang_unused;
  logic [31:0] amount;
  logic [32:0] dep_sum;
  logic        cancel;
  logic        card_ok;

  assign amount  = {25'd0, inputAmount};
  assign dep_sum = {1'b0, Current_Balance} + {1'b0, amount};
  assign cancel  = ejectCard && (state != IDLE) && (state != FINISH);

`ifdef ATM_PIN_LOCKOUT_EN
  localparam int TW = $clog2(MAX_TRIES + 1);
  logic [TW-1:0] tries;
  logic          lock;
  assign card_ok = cardIn && !lock;
`else
  assign card_ok = cardIn;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= IDLE;
      lang_unused             <= 1'b0;
      correctPassword         <= 1'b0;
      Balance_Shown           <= 1'b0;
      Deposited_Successfully  <= 1'b0;
      Withdrawed_Successfully <= 1'b0;
      Input_Approved          <= 1'b0;
      ATM_Usage_Finished      <= 1'b0;
      Current_Balance         <= INIT_BALANCE;
`ifdef ATM_PIN_LOCKOUT_EN
      tries                   <= '0;
      lock                    <= 1'b0;
`endif
    end else begin
      Balance_Shown           <= 1'b0;
      Deposited_Successfully  <= 1'b0;
      Withdrawed_Successfully <= 1'b0;
      Input_Approved          <= 1'b0;
      ATM_Usage_Finished      <= 1'b0;
      // Eject wins over every transition and blocks balance updates.
      if (cancel) begin
        state <= FINISH;
      end else begin
        case (state)
          IDLE: if (card_ok) state <= LANG;
          LANG: begin
            lang_unused <= Language;
            state       <= PIN;
          end
          PIN: begin
            if (password == PASSWORD) begin
              correctPassword <= 1'b1;
              state           <= MENU;
`ifdef ATM_PIN_LOCKOUT_EN
              tries           <= '0;
            end else if (int'(tries) + 1 >= MAX_TRIES) begin
              tries <= '0;
              lock  <= 1'b1;
              state <= FINISH;
            end else begin
              tries <= tries + 1'b1;
`endif
            end
          end
          MENU: begin
            unique case (opCode)
              OP_BAL:  state <= BALANCE;
              OP_DEP:  state <= DEPOSIT;
              OP_WDR:  state <= WITHDRAW;
              OP_EXIT: state <= FINISH;
            endcase
          end
          BALANCE: begin
            Balance_Shown <= 1'b1;
            state         <= ANOTHER;
          end
          DEPOSIT: begin
            if (moneyDeposited) begin
              if (amount != 0 && !dep_sum[32]) begin
                Current_Balance        <= dep_sum[31:0];
                Deposited_Successfully <= 1'b1;
                Input_Approved         <= 1'b1;
              end
              state <= ANOTHER;
            end
          end
          WITHDRAW: begin
            if (amount != 0 && amount <= Current_Balance) begin
              Current_Balance         <= Current_Balance - amount;
              Withdrawed_Successfully <= 1'b1;
              Input_Approved          <= 1'b1;
            end
            state <= ANOTHER;
          end
          ANOTHER: state <= Another_Operation ? MENU : FINISH;
          FINISH: begin
            ATM_Usage_Finished <= 1'b1;
            correctPassword    <= 1'b0;
            state              <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: expected pulse events are queued
// as stimulus is driven and matched against pulses seen on the outputs.
module tb_atm_controller;

  typedef struct packed {
    logic [4:0]  p;
    logic [31:0] bal;
  } ev_t;

  localparam logic [4:0] EV_B = 5'b10000;
  localparam logic [4:0] EV_D = 5'b01010;
  localparam logic [4:0] EV_W = 5'b00110;
  localparam logic [4:0] EV_F = 5'b00001;
  localparam logic [3:0] PIN_OK = 4'b1010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cardIn = 1'b0;
  logic        Language = 1'b0;
  logic [3:0]  password = 4'd0;
  logic [1:0]  opCode = 2'd0;
  logic [6:0]  inputAmount = 7'd0;
  logic        moneyDeposited = 1'b0;
  logic        Another_Operation = 1'b0;
  logic        ejectCard = 1'b0;
  logic        correctPassword;
  logic        Balance_Shown;
  logic        Deposited_Successfully;
  logic        Withdrawed_Successfully;
  logic        Input_Approved;
  logic        ATM_Usage_Finished;
  logic [31:0] Current_Balance;

  int   passed = 0;
  int   total = 0;
  logic [31:0] mbal = 32'd1000;
  ev_t  expq[$];
  ev_t  obsq[$];

  atm_controller dut (
    .clk(clk),
    .reset(reset),
    .cardIn(cardIn),
    .Language(Language),
    .password(password),
    .opCode(opCode),
    .inputAmount(inputAmount),
    .moneyDeposited(moneyDeposited),
    .Another_Operation(Another_Operation),
    .ejectCard(ejectCard),
    .correctPassword(correctPassword),
    .Balance_Shown(Balance_Shown),
    .Deposited_Successfully(Deposited_Successfully),
    .Withdrawed_Successfully(Withdrawed_Successfully),
    .Input_Approved(Input_Approved),
    .ATM_Usage_Finished(ATM_Usage_Finished),
    .Current_Balance(Current_Balance)
  );

  always #5 clk = ~clk;

  logic [4:0] pulses;
  assign pulses = {Balance_Shown, Deposited_Successfully,
                   Withdrawed_Successfully, Input_Approved,
                   ATM_Usage_Finished};

  always @(negedge clk)
    if (reset && |pulses) obsq.push_back('{p: pulses, bal: Current_Balance});

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cardIn = 0; ejectCard = 0; moneyDeposited = 0;
    Another_Operation = 0; opCode = 0; inputAmount = 0;
    repeat (2) @(negedge clk);
    mbal = 32'd1000;
    expq.delete();
    obsq.delete();
  endtask

  task automatic begin_session();
    cardIn = 1'b1;
    password = PIN_OK;
    Language = $urandom_range(0, 1);
    @(negedge clk);
    cardIn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tail(input bit another);
    Another_Operation = another;
    @(negedge clk);
    if (!another) begin
      expq.push_back('{p: EV_F, bal: mbal});
      @(negedge clk);
    end
  endtask

  task automatic op_balance(input bit another);
    opCode = 2'b00;
    @(negedge clk);
    expq.push_back('{p: EV_B, bal: mbal});
    @(negedge clk);
    tail(another);
  endtask

  task automatic op_deposit(input logic [6:0] amt, input bit another);
    opCode = 2'b01;
    inputAmount = amt;
    moneyDeposited = 1'b0;
    repeat (2) @(negedge clk);
    moneyDeposited = 1'b1;
    if (amt != 0 && ({1'b0, mbal} + 33'(amt)) <= 33'hFFFF_FFFF) begin
      mbal = mbal + 32'(amt);
      expq.push_back('{p: EV_D, bal: mbal});
    end
    @(negedge clk);
    moneyDeposited = 1'b0;
    tail(another);
  endtask

  task automatic op_withdraw(input logic [6:0] amt, input bit another);
    opCode = 2'b10;
    inputAmount = amt;
    @(negedge clk);
    if (amt != 0 && 32'(amt) <= mbal) begin
      mbal = mbal - 32'(amt);
      expq.push_back('{p: EV_W, bal: mbal});
    end
    @(negedge clk);
    tail(another);
  endtask

  task automatic op_exit();
    opCode = 2'b11;
    @(negedge clk);
    expq.push_back('{p: EV_F, bal: mbal});
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({correctPassword, pulses} !== 6'd0)
      $display("FAIL reset_outs: got %b want 000000", {correctPassword, pulses});
    else passed++;
    total++;
    if (Current_Balance !== 32'd1000)
      $display("FAIL reset_bal: got %0d want 1000", Current_Balance);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_balance();
    do_reset();
    reset = 1'b1;
    begin_session();
    total++;
    if (correctPassword !== 1'b1)
      $display("FAIL pin_ok: got %b want 1", correctPassword);
    else passed++;
    op_balance(1'b0);
    total++;
    if (correctPassword !== 1'b0)
      $display("FAIL pin_clear: got %b want 0", correctPassword);
    else passed++;
    @(negedge clk);
    while (expq.size() > 0) begin
      ev_t e, o;
      e = expq.pop_front();
      total++;
      if (obsq.size() == 0)
        $display("FAIL balance_ev: got none want p=%b bal=%0d", e.p, e.bal);
      else begin
        o = obsq.pop_front();
        if (o !== e)
          $display("FAIL balance_ev: got p=%b bal=%0d want p=%b bal=%0d",
                   o.p, o.bal, e.p, e.bal);
        else passed++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL balance_extra: got %0d want 0", obsq.size());
    else passed++;
    obsq.delete();
  endtask

  task automatic test_deposit();
    do_reset();
    reset = 1'b1;
    begin_session();
    op_deposit(7'd100, 1'b1);
    op_deposit(7'd0, 1'b1);
    op_deposit(7'd127, 1'b1);
    op_balance(1'b0);
    @(negedge clk);
    total++;
    if (Current_Balance !== 32'd1227)
      $display("FAIL deposit_bal: got %0d want 1227", Current_Balance);
    else passed++;
    while (expq.size() > 0) begin
      ev_t e, o;
      e = expq.pop_front();
      total++;
      if (obsq.size() == 0)
        $display("FAIL deposit_ev: got none want p=%b bal=%0d", e.p, e.bal);
      else begin
        o = obsq.pop_front();
        if (o !== e)
          $display("FAIL deposit_ev: got p=%b bal=%0d want p=%b bal=%0d",
                   o.p, o.bal, e.p, e.bal);
        else passed++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL deposit_extra: got %0d want 0", obsq.size());
    else passed++;
    obsq.delete();
  endtask

  task automatic test_withdraw();
    do_reset();
    reset = 1'b1;
    begin_session();
    op_withdraw(7'd127, 1'b1);
    total++;
    if (Current_Balance !== 32'd873)
      $display("FAIL withdraw_127: got %0d want 873", Current_Balance);
    else passed++;
    for (int i = 0; i < 6; i++) op_withdraw(7'd127, 1'b1);
    op_withdraw(7'd61, 1'b1);
    op_withdraw(7'd100, 1'b1);
    total++;
    if (Current_Balance !== 32'd50)
      $display("FAIL withdraw_over: got %0d want 50", Current_Balance);
    else passed++;
    op_withdraw(7'd0, 1'b1);
    op_withdraw(7'd50, 1'b0);
    @(negedge clk);
    total++;
    if (Current_Balance !== 32'd0)
      $display("FAIL withdraw_all: got %0d want 0", Current_Balance);
    else passed++;
    while (expq.size() > 0) begin
      ev_t e, o;
      e = expq.pop_front();
      total++;
      if (obsq.size() == 0)
        $display("FAIL withdraw_ev: got none want p=%b bal=%0d", e.p, e.bal);
      else begin
        o = obsq.pop_front();
        if (o !== e)
          $display("FAIL withdraw_ev: got p=%b bal=%0d want p=%b bal=%0d",
                   o.p, o.bal, e.p, e.bal);
        else passed++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL withdraw_extra: got %0d want 0", obsq.size());
    else passed++;
    obsq.delete();
  endtask

  task automatic test_wrong_pin();
    do_reset();
    reset = 1'b1;
    cardIn = 1'b1;
    password = 4'b0000;
    @(negedge clk);
    cardIn = 1'b0;
    repeat (4) @(negedge clk);
`ifdef ATM_PIN_LOCKOUT_EN
    expq.push_back('{p: EV_F, bal: mbal});
    repeat (2) @(negedge clk);
    cardIn = 1'b1;
    password = PIN_OK;
    repeat (6) @(negedge clk);
    cardIn = 1'b0;
    total++;
    if (correctPassword !== 1'b0)
      $display("FAIL lockout_card: got %b want 0", correctPassword);
    else passed++;
`else
    repeat (4) @(negedge clk);
    total++;
    if (correctPassword !== 1'b0)
      $display("FAIL wrong_pin: got %b want 0", correctPassword);
    else passed++;
    password = PIN_OK;
    @(negedge clk);
    total++;
    if (correctPassword !== 1'b1)
      $display("FAIL late_pin: got %b want 1", correctPassword);
    else passed++;
    op_exit();
`endif
    @(negedge clk);
    while (expq.size() > 0) begin
      ev_t e, o;
      e = expq.pop_front();
      total++;
      if (obsq.size() == 0)
        $display("FAIL pin_ev: got none want p=%b bal=%0d", e.p, e.bal);
      else begin
        o = obsq.pop_front();
        if (o !== e)
          $display("FAIL pin_ev: got p=%b bal=%0d want p=%b bal=%0d",
                   o.p, o.bal, e.p, e.bal);
        else passed++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL pin_extra: got %0d want 0", obsq.size());
    else passed++;
    obsq.delete();
  endtask

  task automatic test_eject();
    do_reset();
    reset = 1'b1;
    begin_session();
    opCode = 2'b01;
    inputAmount = 7'd50;
    @(negedge clk);
    moneyDeposited = 1'b1;
    ejectCard = 1'b1;
    @(negedge clk);
    moneyDeposited = 1'b0;
    ejectCard = 1'b0;
    expq.push_back('{p: EV_F, bal: mbal});
    @(negedge clk);
    total++;
    if (correctPassword !== 1'b0 || Current_Balance !== 32'd1000)
      $display("FAIL eject: got pw=%b bal=%0d want pw=0 bal=1000",
               correctPassword, Current_Balance);
    else passed++;
    @(negedge clk);
    while (expq.size() > 0) begin
      ev_t e, o;
      e = expq.pop_front();
      total++;
      if (obsq.size() == 0)
        $display("FAIL eject_ev: got none want p=%b bal=%0d", e.p, e.bal);
      else begin
        o = obsq.pop_front();
        if (o !== e)
          $display("FAIL eject_ev: got p=%b bal=%0d want p=%b bal=%0d",
                   o.p, o.bal, e.p, e.bal);
        else passed++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL eject_extra: got %0d want 0", obsq.size());
    else passed++;
    obsq.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    reset = 1'b1;
    begin_session();
    op_withdraw(7'd10, 1'b1);
    op_deposit(7'd5, 1'b1);
    op_exit();
    total++;
    if (correctPassword !== 1'b0)
      $display("FAIL exit_pw: got %b want 0", correctPassword);
    else passed++;
    begin_session();
    op_balance(1'b1);
    @(negedge clk);
    while (expq.size() > 0) begin
      ev_t e, o;
      e = expq.pop_front();
      total++;
      if (obsq.size() == 0)
        $display("FAIL b2b_ev: got none want p=%b bal=%0d", e.p, e.bal);
      else begin
        o = obsq.pop_front();
        if (o !== e)
          $display("FAIL b2b_ev: got p=%b bal=%0d want p=%b bal=%0d",
                   o.p, o.bal, e.p, e.bal);
        else passed++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL b2b_extra: got %0d want 0", obsq.size());
    else passed++;
    obsq.delete();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (Current_Balance !== 32'd1000 || correctPassword !== 1'b0)
      $display("FAIL mid_reset: got bal=%0d pw=%b want bal=1000 pw=0",
               Current_Balance, correctPassword);
    else passed++;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_balance();
    test_deposit();
    test_withdraw();
    test_wrong_pin();
    test_eject();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
